uart_rx_ctrl: RTL and testbench

//  UART receive controller: framing FSM, mid-bit sampler and deserializer for the UART_Rx path.

---
 rtl/uart_rx_pkg.sv | 32 +++
 rtl/uart_rx_sampler.sv | 54 +++++
 rtl/uart_rx_ctrl.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared definitions for the UART receive controller:
//   - rx_state_e   : framing FSM state encoding
//   - OVERSAMPLE   : ticks per bit (edge counter wraps after BIT_END)
//   - SAMPLE_*     : tick indices used by the mid-bit sampler
//   - BIT_END      : tick index where each bit is decided
//   - PAR_EVEN/ODD : encoding of the PAR_TYP input
//   - maj3()       : 2-of-3 vote used by the majority sampler
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int         OVERSAMPLE   = 16;
  localparam logic [4:0] SAMPLE_EARLY = 5'd7;
  localparam logic [4:0] SAMPLE_MID   = 5'd8;
  localparam logic [4:0] SAMPLE_LATE  = 5'd9;
  localparam logic [4:0] BIT_END      = 5'(OVERSAMPLE - 1);

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Mid-bit sampler for the UART receive path. The sampled value is stable
//   from the sample tick until the next bit's sample tick, so the FSM can
//   consume it at the bit end (edge_cnt == 15).
//   Build option UART_RX_MAJORITY_EN:
//     defined     : sample = majority of RX_IN captured at ticks 7, 8, 9
//     not defined : sample = RX_IN captured at tick 8
// Ports
//   CLK      in  clock (oversample tick rate)
//   RST      in  synchronous active-high reset
//   RX_IN    in  serial line
//   edge_cnt in  tick index within the current bit
//   sample   out sampled bit value
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [4:0] edge_cnt,
  output logic       sample
);

`ifdef UART_RX_MAJORITY_EN
  logic s_early, s_mid, s_late;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_early <= 1'b0;
      s_mid   <= 1'b0;
      s_late  <= 1'b0;
    end else begin
      if (edge_cnt == SAMPLE_EARLY) s_early <= RX_IN;
      if (edge_cnt == SAMPLE_MID)   s_mid   <= RX_IN;
      if (edge_cnt == SAMPLE_LATE)  s_late  <= RX_IN;
    end
  end

  assign sample = maj3(s_early, s_mid, s_late);
`else
  logic s_mid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_mid <= 1'b0;
    end else if (edge_cnt == SAMPLE_MID) begin
      s_mid <= RX_IN;
    end
  end

  assign sample = s_mid;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   UART receive controller: framing FSM, deserializer and parity/stop
//   checks. Works with an external edge/bit counter running at 16 ticks per
//   bit; edge_bit_en enables that counter whenever a frame is in progress.
//   Build option UART_RX_MAJORITY_EN selects the 3-tick majority sampler
//   (see uart_rx_sampler); result pulse timing is the same in both builds.
// Ports
//   CLK, RST     clock, synchronous active-high reset
//   RX_IN        serial line, idle high
//   PAR_EN       1 = parity bit present (latched at frame start)
//   PAR_TYP      0 = even, 1 = odd (latched at frame start)
//   bit_cnt      bit index from the counter, 0 = start bit
//   edge_cnt     tick index within the current bit, 0..15
//   edge_bit_en  counter enable, high in every state except IDLE
//   P_DATA       last good byte, held until the next good frame
//   data_valid   one-cycle pulse, frame good
//   par_err      one-cycle pulse, parity mismatch
//   stp_err      one-cycle pulse, stop bit sampled 0
//   state_dbg    current FSM state, for observation only
// Handshake: data_valid is a strobe with no ready; P_DATA is valid in the
// data_valid cycle and stays stable until the next data_valid.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [3:0]            bit_cnt,
  input  logic [4:0]            edge_cnt,
  output logic                  edge_bit_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output rx_state_e             state_dbg
);

  localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_WIDTH);
  localparam logic [3:0] PARITY_IDX    = 4'(DATA_WIDTH + 1);

  rx_state_e             state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic [DATA_WIDTH-1:0] p_data_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_typ_q, par_typ_nxt;
  logic                  par_flag_q, par_flag_nxt;
  logic                  valid_nxt, par_err_nxt, stp_err_nxt;
  logic                  sample;
  logic                  bit_end, edge_bad, exp_par;
  logic [3:0]            stop_idx;

  uart_rx_sampler u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .RX_IN    (RX_IN),
    .edge_cnt (edge_cnt),
    .sample   (sample)
  );

  assign bit_end     = (edge_cnt == BIT_END);
  assign edge_bad    = (edge_cnt > BIT_END);
  assign stop_idx    = par_en_q ? 4'(DATA_WIDTH + 2) : 4'(DATA_WIDTH + 1);
  assign exp_par     = (^shift_q) ^ (par_typ_q == PAR_ODD);
  // Registered-state decode only, so the counter clears the cycle after IDLE.
  assign edge_bit_en = (state != IDLE);
  assign state_dbg   = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      shift_q    <= '0;
      P_DATA     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_flag_q <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_q    <= shift_nxt;
      P_DATA     <= p_data_nxt;
      par_en_q   <= par_en_nxt;
      par_typ_q  <= par_typ_nxt;
      par_flag_q <= par_flag_nxt;
      data_valid <= valid_nxt;
      par_err    <= par_err_nxt;
      stp_err    <= stp_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_q;
    p_data_nxt   = P_DATA;
    par_en_nxt   = par_en_q;
    par_typ_nxt  = par_typ_q;
    par_flag_nxt = par_flag_q;
    valid_nxt    = 1'b0;
    par_err_nxt  = 1'b0;
    stp_err_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (!RX_IN) begin
          state_nxt    = START;
          par_en_nxt   = PAR_EN;
          par_typ_nxt  = PAR_TYP;
          par_flag_nxt = 1'b0;
        end
      end

      START: begin
        if (bit_cnt != 4'd0 || edge_bad) begin
          state_nxt = IDLE;
        end else if (bit_end) begin
          // A start bit that reads high at mid-bit was a line glitch.
          state_nxt = sample ? IDLE : DATA;
        end
      end

      DATA: begin
        if (bit_cnt == 4'd0 || bit_cnt > LAST_DATA_IDX || edge_bad) begin
          state_nxt = IDLE;
        end else if (bit_end) begin
          shift_nxt = {sample, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt == LAST_DATA_IDX) begin
            state_nxt = par_en_q ? PARITY : STOP;
          end
        end
      end

      PARITY: begin
        if (bit_cnt != PARITY_IDX || edge_bad) begin
          state_nxt = IDLE;
        end else if (bit_end) begin
          if (sample != exp_par) par_flag_nxt = 1'b1;
          state_nxt = STOP;
        end
      end

      STOP: begin
        if (bit_cnt != stop_idx || edge_bad) begin
          state_nxt = IDLE;
        end else if (bit_end) begin
          state_nxt = IDLE;
          // A framing error masks any parity error in the same frame.
          if (!sample) begin
            stp_err_nxt = 1'b1;
          end else if (par_flag_q) begin
            par_err_nxt = 1'b1;
          end else begin
            valid_nxt  = 1'b1;
            p_data_nxt = shift_q;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic       RX_IN   = 1'b1;
  logic       PAR_EN  = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [3:0] bit_cnt;
  logic [4:0] edge_cnt;
  logic       edge_bit_en;
  logic [W-1:0] P_DATA;
  logic       data_valid, par_err, stp_err;
  rx_state_e  state_dbg;

  uart_rx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .bit_cnt     (bit_cnt),
    .edge_cnt    (edge_cnt),
    .edge_bit_en (edge_bit_en),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .state_dbg   (state_dbg)
  );

  // Edge/bit counter model: counts 0..15 ticks per bit while enabled.
  logic [3:0] cnt_bit;
  logic [4:0] cnt_edge;
  logic       bad_cnt = 1'b0;
  always_ff @(posedge CLK) begin
    if (RST || !edge_bit_en) begin
      cnt_bit  <= 4'd0;
      cnt_edge <= 5'd0;
    end else if (cnt_edge == 5'd15) begin
      cnt_edge <= 5'd0;
      cnt_bit  <= cnt_bit + 4'd1;
    end else begin
      cnt_edge <= cnt_edge + 5'd1;
    end
  end
  assign bit_cnt  = bad_cnt ? 4'd12 : cnt_bit;
  assign edge_cnt = cnt_edge;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- pulse monitor ----------------
  int         ev_n = 0;
  int         ev_cyc = 0;
  logic [2:0] ev_flags = 3'b000;   // {data_valid, par_err, stp_err}
  logic [W-1:0] ev_pdata = '0;
  always @(negedge CLK) begin
    if (data_valid || par_err || stp_err) begin
      ev_n     = ev_n + 1;
      ev_cyc   = cyc;
      ev_flags = {data_valid, par_err, stp_err};
      ev_pdata = P_DATA;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one frame, 16 ticks per bit. glitch_bit >= 0 pulls that frame
  // bit low for one tick, the one captured at edge_cnt 8.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic pflip, input logic stopb, input int glitch_bit,
                            input logic midchg, input int max_cycles);
    logic [11:0] bits;
    int nb;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[1+i] = d[i];
    nb = W + 1;
    if (pe) begin
      bits[nb] = (^d) ^ pt ^ pflip;
      nb++;
    end
    bits[nb] = stopb;
    nb++;
    PAR_EN  = pe;
    PAR_TYP = pt;
    for (int c = 0; c < nb * 16 && c < max_cycles; c++) begin
      RX_IN = bits[c / 16];
      if (c / 16 == glitch_bit && c % 16 == 9) RX_IN = 1'b0;
      if (midchg && c == 20) begin
        PAR_EN  = ~pe;
        PAR_TYP = ~pt;
      end
      tick();
    end
    RX_IN = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] d;
    logic       pe, pt, pflip, stopb, midchg;
    int         glitch;
    logic [2:0] exp_flags;
    logic [7:0] exp_pdata;
    int         exp_lat;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    int base, drive_cyc, lat;
    logic [7:0] glitch_exp;

`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hFF;
`else
    glitch_exp = 8'hFB;
`endif
    //         d      pe    pt    flip  stop  mid   glitch flags    pdata       lat
    vecs[0]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 3'b100, 8'hA5,      161};
    vecs[1]  = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 3'b100, 8'h3C,      177};
    vecs[2]  = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, 3'b010, 8'h3C,      177};
    vecs[3]  = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 3'b001, 8'h3C,      161};
    vecs[4]  = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, 3'b001, 8'h3C,      177};
    vecs[5]  = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, 3'b100, 8'h81,      177};
    vecs[6]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, 3'b100, 8'h00,      177};
    vecs[7]  = '{8'h6B, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, 3'b010, 8'h00,      177};
    vecs[8]  = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1, 3'b100, 8'h3C,      177};
    vecs[9]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  3, 3'b100, glitch_exp, 161};
    vecs[10] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 3'b100, 8'h5A,      161};

    // ---- reset state ----
    RST = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_edge_bit_en", 32'(edge_bit_en), 32'd0);
    check("rst_p_data",      32'(P_DATA),      32'd0);
    check("rst_pulses",      32'({data_valid, par_err, stp_err}), 32'd0);
    check("rst_state",       32'(state_dbg),   32'(IDLE));
    RST = 1'b0;
    idle(4);

    // ---- table-driven frames ----
    for (int v = 0; v < NV; v++) begin
      base      = ev_n;
      drive_cyc = cyc;
      send_frame(vecs[v].d, vecs[v].pe, vecs[v].pt, vecs[v].pflip, vecs[v].stopb,
                 vecs[v].glitch, vecs[v].midchg, 1000);
      idle(24);
      lat = ev_cyc - drive_cyc;
      exp_q.push_back(vecs[v].exp_pdata);
      check($sformatf("v%0d_pulse_count", v), 32'(ev_n - base), 32'd1);
      check($sformatf("v%0d_flags", v),       32'(ev_flags),     32'(vecs[v].exp_flags));
      check($sformatf("v%0d_latency", v),     32'(lat),          32'(vecs[v].exp_lat));
      check($sformatf("v%0d_pdata_at_pulse", v), 32'(ev_pdata),  32'(exp_q.pop_front()));
      check($sformatf("v%0d_pdata_held", v),  32'(P_DATA),       32'(vecs[v].exp_pdata));
      check($sformatf("v%0d_edge_bit_en", v), 32'(edge_bit_en),  32'd0);
    end

    // ---- start glitch: low 4 ticks then high ----
    base = ev_n;
    RX_IN = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    RX_IN = 1'b1;
    tick();
    tick();
    check("glitch_counting", 32'(edge_bit_en), 32'd1);
    idle(30);
    check("glitch_back_idle", 32'(edge_bit_en), 32'd0);
    check("glitch_state",     32'(state_dbg),   32'(IDLE));
    check("glitch_no_pulse",  32'(ev_n - base), 32'd0);
    check("glitch_pdata",     32'(P_DATA),      32'h5A);

    // ---- counter out of range mid-frame forces IDLE ----
    base = ev_n;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 40);
    check("badcnt_in_frame", 32'(edge_bit_en), 32'd1);
    bad_cnt = 1'b1;
    tick();
    bad_cnt = 1'b0;
    check("badcnt_abort", 32'(edge_bit_en), 32'd0);
    idle(200);
    check("badcnt_no_pulse", 32'(ev_n - base), 32'd0);

    // ---- back-to-back 0x55 frames, reset during the second ----
    base = ev_n;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1000);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 70);
    check("b2b_second_active", 32'(edge_bit_en), 32'd1);
    check("b2b_first_valid",   32'(ev_flags),    32'b100);
    check("b2b_first_pdata",   32'(P_DATA),      32'h55);
    RST = 1'b1;
    tick();
    check("midrst_edge_bit_en", 32'(edge_bit_en), 32'd0);
    check("midrst_p_data",      32'(P_DATA),      32'd0);
    check("midrst_pulses",      32'({data_valid, par_err, stp_err}), 32'd0);
    check("midrst_state",       32'(state_dbg),   32'(IDLE));
    RST = 1'b0;
    idle(200);
    check("midrst_pulse_count", 32'(ev_n - base), 32'd1);
    check("midrst_p_data_after", 32'(P_DATA),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
